// File: rtl/rvfi_commit_tracker.sv
// rvfi_commit_tracker: per-ROB-entry RVFI metadata capture with in-order multi-channel packet emission.
// Define RVFI_TRACKER_CHECK_EN to add the sticky protocol error output err.
module rvfi_commit_tracker #(
    parameter int  ROB_DEPTH = 16,
    parameter int  CHANNELS  = 2,
    localparam int IDX_W     = $clog2(ROB_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      disp_valid,
    input  logic [IDX_W-1:0]          disp_rob_idx,
    input  logic [31:0]               disp_inst,
    input  logic [31:0]               disp_pc,
    input  logic [4:0]                disp_rs1_addr,
    input  logic [4:0]                disp_rs2_addr,
    input  logic [4:0]                disp_rd_addr,
    input  logic                      wb_valid,
    input  logic [IDX_W-1:0]          wb_rob_idx,
    input  logic [31:0]               wb_rs1_rdata,
    input  logic [31:0]               wb_rs2_rdata,
    input  logic [31:0]               wb_rd_wdata,
    input  logic                      wb_pc_wdata_valid,
    input  logic [31:0]               wb_pc_wdata,
    input  logic                      mem_valid,
    input  logic [IDX_W-1:0]          mem_rob_idx,
    input  logic [31:0]               mem_addr,
    input  logic [31:0]               mem_rdata,
    input  logic [31:0]               mem_wdata,
    input  logic [3:0]                mem_rmask,
    input  logic [3:0]                mem_wmask,
    input  logic [CHANNELS-1:0]       commit_valid,
    input  logic [CHANNELS*IDX_W-1:0] commit_rob_idx,
    input  logic                      flush,
    output logic [CHANNELS-1:0]       rvfi_valid,
    output logic [CHANNELS*64-1:0]    rvfi_order,
    output logic [CHANNELS*32-1:0]    rvfi_inst,
    output logic [CHANNELS*32-1:0]    rvfi_rs1_rdata,
    output logic [CHANNELS*32-1:0]    rvfi_rs2_rdata,
    output logic [CHANNELS*32-1:0]    rvfi_rd_wdata,
    output logic [CHANNELS*32-1:0]    rvfi_pc_rdata,
    output logic [CHANNELS*32-1:0]    rvfi_pc_wdata,
    output logic [CHANNELS*32-1:0]    rvfi_mem_addr,
    output logic [CHANNELS*32-1:0]    rvfi_mem_rdata,
    output logic [CHANNELS*32-1:0]    rvfi_mem_wdata,
    output logic [CHANNELS*5-1:0]     rvfi_rs1_addr,
    output logic [CHANNELS*5-1:0]     rvfi_rs2_addr,
    output logic [CHANNELS*5-1:0]     rvfi_rd_addr,
    output logic [CHANNELS*4-1:0]     rvfi_mem_rmask,
    output logic [CHANNELS*4-1:0]     rvfi_mem_wmask
`ifdef RVFI_TRACKER_CHECK_EN
    ,
    output logic                      err
`endif
);
    typedef struct packed {
        logic [63:0] order;
        logic [31:0] inst, rs1_rdata, rs2_rdata, rd_wdata, pc_rdata, pc_wdata, mem_addr, mem_rdata, mem_wdata;
        logic [4:0]  rs1_addr, rs2_addr, rd_addr;
        logic [3:0]  mem_rmask, mem_wmask;
    } pkt_t;

    logic [ROB_DEPTH-1:0] valid_q, wb_done_q, mem_done_q, pcw_set_q;
    logic [31:0] inst_q [ROB_DEPTH];
    logic [31:0] pc_q [ROB_DEPTH];
    logic [31:0] rs1_rdata_q [ROB_DEPTH];
    logic [31:0] rs2_rdata_q [ROB_DEPTH];
    logic [31:0] rd_wdata_q [ROB_DEPTH];
    logic [31:0] pc_wdata_q [ROB_DEPTH];
    logic [31:0] mem_addr_q [ROB_DEPTH];
    logic [31:0] mem_rdata_q [ROB_DEPTH];
    logic [31:0] mem_wdata_q [ROB_DEPTH];
    logic [4:0]  rs1_addr_q [ROB_DEPTH];
    logic [4:0]  rs2_addr_q [ROB_DEPTH];
    logic [4:0]  rd_addr_q [ROB_DEPTH];
    logic [3:0]  mem_rmask_q [ROB_DEPTH];
    logic [3:0]  mem_wmask_q [ROB_DEPTH];

    logic [ROB_DEPTH-1:0] disp_hit, wb_hit, mem_hit, com_hit;
    logic [CHANNELS-1:0]  ok, rvfi_valid_q;
    logic [IDX_W-1:0]     cidx [CHANNELS];
    pkt_t                 pkt_d [CHANNELS];
    pkt_t                 pkt_q [CHANNELS];
    logic [63:0]          order_d, order_q;
    logic                 run;

    // Only the contiguous low run of commit_valid retires; anything above a gap is dropped.
    always_comb begin
        run = 1'b1;
        order_d = order_q;
        for (int i = 0; i < CHANNELS; i++) begin
            run = run & commit_valid[i];
            ok[i] = run;
            cidx[i] = commit_rob_idx[i*IDX_W +: IDX_W];
            order_d = order_d + 64'(run);
            pkt_d[i].order     = order_q + 64'(i);
            pkt_d[i].inst      = inst_q[cidx[i]];
            pkt_d[i].pc_rdata  = pc_q[cidx[i]];
            pkt_d[i].rs1_addr  = rs1_addr_q[cidx[i]];
            pkt_d[i].rs2_addr  = rs2_addr_q[cidx[i]];
            pkt_d[i].rd_addr   = rd_addr_q[cidx[i]];
            pkt_d[i].rs1_rdata = (rs1_addr_q[cidx[i]] == 5'd0) ? 32'd0 : rs1_rdata_q[cidx[i]];
            pkt_d[i].rs2_rdata = (rs2_addr_q[cidx[i]] == 5'd0) ? 32'd0 : rs2_rdata_q[cidx[i]];
            pkt_d[i].rd_wdata  = (rd_addr_q[cidx[i]] == 5'd0) ? 32'd0 : rd_wdata_q[cidx[i]];
            pkt_d[i].pc_wdata  = pcw_set_q[cidx[i]] ? pc_wdata_q[cidx[i]] :
                                 pc_q[cidx[i]] + ((inst_q[cidx[i]][1:0] == 2'b11) ? 32'd4 : 32'd2);
            pkt_d[i].mem_addr  = mem_done_q[cidx[i]] ? mem_addr_q[cidx[i]] : 32'd0;
            pkt_d[i].mem_rdata = mem_done_q[cidx[i]] ? mem_rdata_q[cidx[i]] : 32'd0;
            pkt_d[i].mem_wdata = mem_done_q[cidx[i]] ? mem_wdata_q[cidx[i]] : 32'd0;
            pkt_d[i].mem_rmask = mem_done_q[cidx[i]] ? mem_rmask_q[cidx[i]] : 4'd0;
            pkt_d[i].mem_wmask = mem_done_q[cidx[i]] ? mem_wmask_q[cidx[i]] : 4'd0;
        end
    end

    always_comb begin
        com_hit = '0;
        for (int j = 0; j < ROB_DEPTH; j++) begin
            disp_hit[j] = disp_valid && !flush && disp_rob_idx == IDX_W'(j);
            wb_hit[j]   = wb_valid && wb_rob_idx == IDX_W'(j) && !disp_hit[j];
            mem_hit[j]  = mem_valid && mem_rob_idx == IDX_W'(j) && !disp_hit[j];
            for (int i = 0; i < CHANNELS; i++)
                com_hit[j] = com_hit[j] | (ok[i] && cidx[i] == IDX_W'(j));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q    <= '0;
            wb_done_q  <= '0;
            mem_done_q <= '0;
            pcw_set_q  <= '0;
        end else begin
            valid_q    <= flush ? '0 : disp_hit | (valid_q & ~com_hit);
            wb_done_q  <= ~disp_hit & (wb_hit | wb_done_q);
            mem_done_q <= ~disp_hit & (mem_hit | mem_done_q);
            pcw_set_q  <= (pcw_set_q & ~disp_hit & ~wb_hit) | (wb_hit & {ROB_DEPTH{wb_pc_wdata_valid}});
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < ROB_DEPTH; j++) begin
            if (disp_hit[j]) begin
                inst_q[j]      <= disp_inst;
                pc_q[j]        <= disp_pc;
                rs1_addr_q[j]  <= disp_rs1_addr;
                rs2_addr_q[j]  <= disp_rs2_addr;
                rd_addr_q[j]   <= disp_rd_addr;
                mem_addr_q[j]  <= '0;
                mem_rdata_q[j] <= '0;
                mem_wdata_q[j] <= '0;
                mem_rmask_q[j] <= '0;
                mem_wmask_q[j] <= '0;
            end
            if (wb_hit[j]) begin
                rs1_rdata_q[j] <= wb_rs1_rdata;
                rs2_rdata_q[j] <= wb_rs2_rdata;
                rd_wdata_q[j]  <= wb_rd_wdata;
                pc_wdata_q[j]  <= wb_pc_wdata;
            end
            if (mem_hit[j]) begin
                mem_addr_q[j]  <= mem_addr;
                mem_rdata_q[j] <= mem_rdata;
                mem_wdata_q[j] <= mem_wdata;
                mem_rmask_q[j] <= mem_rmask;
                mem_wmask_q[j] <= mem_wmask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            order_q      <= '0;
            rvfi_valid_q <= '0;
            for (int i = 0; i < CHANNELS; i++)
                pkt_q[i] <= '0;
        end else begin
            order_q      <= order_d;
            rvfi_valid_q <= ok;
            for (int i = 0; i < CHANNELS; i++)
                pkt_q[i] <= ok[i] ? pkt_d[i] : '0;
        end
    end

    assign rvfi_valid = rvfi_valid_q;
    for (genvar c = 0; c < CHANNELS; c++) begin : g_out
        assign rvfi_order[c*64 +: 64]     = pkt_q[c].order;
        assign rvfi_inst[c*32 +: 32]      = pkt_q[c].inst;
        assign rvfi_rs1_rdata[c*32 +: 32] = pkt_q[c].rs1_rdata;
        assign rvfi_rs2_rdata[c*32 +: 32] = pkt_q[c].rs2_rdata;
        assign rvfi_rd_wdata[c*32 +: 32]  = pkt_q[c].rd_wdata;
        assign rvfi_pc_rdata[c*32 +: 32]  = pkt_q[c].pc_rdata;
        assign rvfi_pc_wdata[c*32 +: 32]  = pkt_q[c].pc_wdata;
        assign rvfi_mem_addr[c*32 +: 32]  = pkt_q[c].mem_addr;
        assign rvfi_mem_rdata[c*32 +: 32] = pkt_q[c].mem_rdata;
        assign rvfi_mem_wdata[c*32 +: 32] = pkt_q[c].mem_wdata;
        assign rvfi_rs1_addr[c*5 +: 5]    = pkt_q[c].rs1_addr;
        assign rvfi_rs2_addr[c*5 +: 5]    = pkt_q[c].rs2_addr;
        assign rvfi_rd_addr[c*5 +: 5]     = pkt_q[c].rd_addr;
        assign rvfi_mem_rmask[c*4 +: 4]   = pkt_q[c].mem_rmask;
        assign rvfi_mem_wmask[c*4 +: 4]   = pkt_q[c].mem_wmask;
    end

`ifdef RVFI_TRACKER_CHECK_EN
    logic err_q, bad;
    // Re-dispatch into an entry retiring in the same cycle is legitimate reuse, not an error.
    always_comb begin
        bad = (commit_valid != ok) || (disp_valid && valid_q[disp_rob_idx] && !com_hit[disp_rob_idx]);
        for (int i = 0; i < CHANNELS; i++)
            bad = bad | (ok[i] && !(valid_q[cidx[i]] && wb_done_q[cidx[i]]));
    end

    always_ff @(posedge clk) begin
        if (!rst)
            err_q <= 1'b0;
        else
            err_q <= err_q | bad;
    end

    assign err = err_q;
`endif
endmodule

// File: tb/tb_rvfi_commit_tracker.sv
// tb_rvfi_commit_tracker: directed stimulus checked every cycle against an entry-level model plus literal spot checks.
module tb_rvfi_commit_tracker;
    logic         clk = 1'b0, rst = 1'b0;
    logic         disp_valid = 1'b0, wb_valid = 1'b0, wb_pc_wdata_valid = 1'b0, mem_valid = 1'b0, flush = 1'b0;
    logic [3:0]   disp_rob_idx = '0, wb_rob_idx = '0, mem_rob_idx = '0;
    logic [31:0]  disp_inst = '0, disp_pc = '0;
    logic [4:0]   disp_rs1_addr = '0, disp_rs2_addr = '0, disp_rd_addr = '0;
    logic [31:0]  wb_rs1_rdata = '0, wb_rs2_rdata = '0, wb_rd_wdata = '0, wb_pc_wdata = '0;
    logic [31:0]  mem_addr = '0, mem_rdata = '0, mem_wdata = '0;
    logic [3:0]   mem_rmask = '0, mem_wmask = '0;
    logic [1:0]   commit_valid = '0;
    logic [7:0]   commit_rob_idx = '0;
    logic [1:0]   rvfi_valid;
    logic [127:0] rvfi_order;
    logic [63:0]  rvfi_inst, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata;
    logic [63:0]  rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [9:0]   rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [7:0]   rvfi_mem_rmask, rvfi_mem_wmask;
`ifdef RVFI_TRACKER_CHECK_EN
    logic         err;
`endif

    int checks = 0, failures = 0;

    rvfi_commit_tracker #(.ROB_DEPTH(16), .CHANNELS(2)) dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_rob_idx(disp_rob_idx), .disp_inst(disp_inst), .disp_pc(disp_pc),
        .disp_rs1_addr(disp_rs1_addr), .disp_rs2_addr(disp_rs2_addr), .disp_rd_addr(disp_rd_addr),
        .wb_valid(wb_valid), .wb_rob_idx(wb_rob_idx), .wb_rs1_rdata(wb_rs1_rdata), .wb_rs2_rdata(wb_rs2_rdata),
        .wb_rd_wdata(wb_rd_wdata), .wb_pc_wdata_valid(wb_pc_wdata_valid), .wb_pc_wdata(wb_pc_wdata),
        .mem_valid(mem_valid), .mem_rob_idx(mem_rob_idx), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_wdata(mem_wdata), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
        .commit_valid(commit_valid), .commit_rob_idx(commit_rob_idx), .flush(flush),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_inst(rvfi_inst),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_mem_addr(rvfi_mem_addr),
        .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata), .rvfi_rs1_addr(rvfi_rs1_addr),
        .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rd_addr(rvfi_rd_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask)
`ifdef RVFI_TRACKER_CHECK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] inst, rs1_rdata, rs2_rdata, rd_wdata, pc_rdata, pc_wdata, mem_addr, mem_rdata, mem_wdata;
        logic [4:0]  rs1_addr, rs2_addr, rd_addr;
        logic [3:0]  mem_rmask, mem_wmask;
    } pkt_t;

    typedef struct {
        bit          v, wb, md, pcs;
        logic [31:0] inst, pc, r1d, r2d, rdd, pcw, ma, mr, mw;
        logic [4:0]  r1, r2, rd;
        logic [3:0]  rm, wm;
    } ent_t;

    ent_t        ent [16];
    pkt_t        exp_p [2];
    logic [1:0]  exp_v;
    logic [63:0] m_order;
    bit          exp_rst, started = 0, dw;
    int          n;

    function automatic pkt_t mk(input int k, input logic [63:0] o);
        pkt_t p;
        p.order     = o;
        p.inst      = ent[k].inst;
        p.pc_rdata  = ent[k].pc;
        p.rs1_addr  = ent[k].r1;
        p.rs2_addr  = ent[k].r2;
        p.rd_addr   = ent[k].rd;
        p.rs1_rdata = (ent[k].r1 == 0) ? 32'd0 : ent[k].r1d;
        p.rs2_rdata = (ent[k].r2 == 0) ? 32'd0 : ent[k].r2d;
        p.rd_wdata  = (ent[k].rd == 0) ? 32'd0 : ent[k].rdd;
        p.pc_wdata  = ent[k].pcs ? ent[k].pcw : ent[k].pc + ((ent[k].inst[1:0] == 2'b11) ? 32'd4 : 32'd2);
        {p.mem_addr, p.mem_rdata, p.mem_wdata, p.mem_rmask, p.mem_wmask} =
            ent[k].md ? {ent[k].ma, ent[k].mr, ent[k].mw, ent[k].rm, ent[k].wm} : 104'd0;
        return p;
    endfunction

    function automatic pkt_t dut_pkt(input int c);
        pkt_t p;
        p.order     = rvfi_order[c*64 +: 64];
        p.inst      = rvfi_inst[c*32 +: 32];
        p.rs1_rdata = rvfi_rs1_rdata[c*32 +: 32];
        p.rs2_rdata = rvfi_rs2_rdata[c*32 +: 32];
        p.rd_wdata  = rvfi_rd_wdata[c*32 +: 32];
        p.pc_rdata  = rvfi_pc_rdata[c*32 +: 32];
        p.pc_wdata  = rvfi_pc_wdata[c*32 +: 32];
        p.mem_addr  = rvfi_mem_addr[c*32 +: 32];
        p.mem_rdata = rvfi_mem_rdata[c*32 +: 32];
        p.mem_wdata = rvfi_mem_wdata[c*32 +: 32];
        p.rs1_addr  = rvfi_rs1_addr[c*5 +: 5];
        p.rs2_addr  = rvfi_rs2_addr[c*5 +: 5];
        p.rd_addr   = rvfi_rd_addr[c*5 +: 5];
        p.mem_rmask = rvfi_mem_rmask[c*4 +: 4];
        p.mem_wmask = rvfi_mem_wmask[c*4 +: 4];
        return p;
    endfunction

    // Entry-level model: what each retiring packet must contain, one cycle later.
    always @(posedge clk) begin
        started = 1;
        if (!rst) begin
            exp_rst = 1;
            exp_v = '0;
            m_order = '0;
            exp_p[0] = '0;
            exp_p[1] = '0;
            for (int k = 0; k < 16; k++) begin
                ent[k].v = 0;
                ent[k].wb = 0;
                ent[k].md = 0;
            end
        end else begin
            exp_rst = 0;
            exp_v = '0;
            n = 0;
            for (int c = 0; c < 2; c++) begin
                exp_p[c] = '0;
                if (commit_valid[c] && n == c) begin
                    exp_v[c] = 1'b1;
                    exp_p[c] = mk(int'(commit_rob_idx[c*4 +: 4]), m_order + 64'(c));
                    n++;
                end
            end
            for (int c = 0; c < n; c++) ent[commit_rob_idx[c*4 +: 4]].v = 0;
            m_order += 64'(n);
            dw = disp_valid && !flush;
            if (flush) for (int k = 0; k < 16; k++) ent[k].v = 0;
            if (dw) begin
                ent[disp_rob_idx].v = 1; ent[disp_rob_idx].wb = 0; ent[disp_rob_idx].md = 0; ent[disp_rob_idx].pcs = 0;
                ent[disp_rob_idx].inst = disp_inst; ent[disp_rob_idx].pc = disp_pc;
                ent[disp_rob_idx].r1 = disp_rs1_addr; ent[disp_rob_idx].r2 = disp_rs2_addr; ent[disp_rob_idx].rd = disp_rd_addr;
                ent[disp_rob_idx].ma = 0; ent[disp_rob_idx].mr = 0; ent[disp_rob_idx].mw = 0;
                ent[disp_rob_idx].rm = 0; ent[disp_rob_idx].wm = 0;
            end
            if (wb_valid && !(dw && wb_rob_idx == disp_rob_idx)) begin
                ent[wb_rob_idx].wb = 1; ent[wb_rob_idx].r1d = wb_rs1_rdata; ent[wb_rob_idx].r2d = wb_rs2_rdata;
                ent[wb_rob_idx].rdd = wb_rd_wdata; ent[wb_rob_idx].pcs = wb_pc_wdata_valid; ent[wb_rob_idx].pcw = wb_pc_wdata;
            end
            if (mem_valid && !(dw && mem_rob_idx == disp_rob_idx)) begin
                ent[mem_rob_idx].md = 1; ent[mem_rob_idx].ma = mem_addr; ent[mem_rob_idx].mr = mem_rdata;
                ent[mem_rob_idx].mw = mem_wdata; ent[mem_rob_idx].rm = mem_rmask; ent[mem_rob_idx].wm = mem_wmask;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            checks++;
            if (rvfi_valid !== exp_v) begin
                failures++;
                $display("FAIL cyc_valid t=%0t got=%b exp=%b", $time, rvfi_valid, exp_v);
            end
            for (int c = 0; c < 2; c++) begin
                if (exp_v[c] || exp_rst) begin
                    checks++;
                    if (dut_pkt(c) !== exp_p[c]) begin
                        failures++;
                        $display("FAIL cyc_pkt%0d t=%0t got=%h exp=%h", c, $time, dut_pkt(c), exp_p[c]);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        disp_valid = 0; wb_valid = 0; wb_pc_wdata_valid = 0; mem_valid = 0; commit_valid = '0; flush = 0;
    endtask

    task automatic disp(input int i, input logic [31:0] pc, input logic [31:0] inst,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        disp_valid = 1; disp_rob_idx = 4'(i); disp_pc = pc; disp_inst = inst;
        disp_rs1_addr = r1; disp_rs2_addr = r2; disp_rd_addr = rd;
    endtask

    task automatic wb(input int i, input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] dr,
                      input logic pv, input logic [31:0] pw);
        wb_valid = 1; wb_rob_idx = 4'(i); wb_rs1_rdata = d1; wb_rs2_rdata = d2; wb_rd_wdata = dr;
        wb_pc_wdata_valid = pv; wb_pc_wdata = pw;
    endtask

    task automatic mem(input int i, input logic [31:0] a, input logic [31:0] rd, input logic [31:0] wd,
                       input logic [3:0] rm, input logic [3:0] wm);
        mem_valid = 1; mem_rob_idx = 4'(i); mem_addr = a; mem_rdata = rd; mem_wdata = wd;
        mem_rmask = rm; mem_wmask = wm;
    endtask

    task automatic com1(input int i);
        commit_valid = 2'b01; commit_rob_idx = {4'd0, 4'(i)};
    endtask

    task automatic com2(input int a, input int b);
        commit_valid = 2'b11; commit_rob_idx = {4'(b), 4'(a)};
    endtask

    task automatic run(input int i, input logic [31:0] pc, input logic [31:0] inst,
                       input logic [4:0] rd, input logic [31:0] rdd);
        disp(i, pc, inst, 5'd1, 5'd2, rd); tick();
        wb(i, 32'h11, 32'h22, rdd, 1'b0, 32'd0); tick();
        com1(i); tick();
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_valid", 64'(rvfi_valid), 64'd0);
        chk("rst_order", rvfi_order[63:0], 64'd0);
        rst = 1;
        tick();

        disp(3, 32'h60000000, 32'h00100093, 5'd0, 5'd0, 5'd1); tick();
        wb(3, 32'h123, 32'h456, 32'h1, 1'b0, 32'd0); tick();
        com1(3); tick();
        chk("t1_valid", 64'(rvfi_valid), 64'd1);
        chk("t1_order", rvfi_order[63:0], 64'd0);
        chk("t1_rd_addr", 64'(rvfi_rd_addr[4:0]), 64'd1);
        chk("t1_rd_wdata", 64'(rvfi_rd_wdata[31:0]), 64'h1);
        chk("t1_pc_wdata", 64'(rvfi_pc_wdata[31:0]), 64'h60000004);
        chk("t1_rs1_zero", 64'(rvfi_rs1_rdata[31:0]), 64'd0);
        tick();
        chk("t1_one_cycle", 64'(rvfi_valid), 64'd0);

        for (int k = 4; k < 8; k++) run(k, 32'h60000100 + 32'(k * 4), 32'h00000013, 5'd2, 32'(k));
        chk("order_4", rvfi_order[63:0], 64'd4);

        disp(8, 32'h60000200, 32'h00000013, 5'd1, 5'd2, 5'd3); tick();
        disp(9, 32'h60000204, 32'h00000013, 5'd1, 5'd2, 5'd4); wb(8, 32'h1, 32'h2, 32'h88, 1'b0, 32'd0); tick();
        wb(9, 32'h3, 32'h4, 32'h99, 1'b0, 32'd0); tick();
        com2(8, 9); tick();
        chk("pair_valid", 64'(rvfi_valid), 64'd3);
        chk("pair_order0", rvfi_order[63:0], 64'd5);
        chk("pair_order1", rvfi_order[127:64], 64'd6);

        run(10, 32'h60000010, 32'h00004501, 5'd10, 32'd0);
        chk("c_order", rvfi_order[63:0], 64'd7);
        chk("c_pc_wdata", 64'(rvfi_pc_wdata[31:0]), 64'h60000012);

        disp(11, 32'h60000020, 32'h0e00006f, 5'd0, 5'd0, 5'd0); tick();
        wb(11, 32'd0, 32'd0, 32'd0, 1'b1, 32'h60000100); tick();
        com1(11); tick();
        chk("j_order", rvfi_order[63:0], 64'd8);
        chk("j_pc_wdata", 64'(rvfi_pc_wdata[31:0]), 64'h60000100);

        disp(12, 32'h60000030, 32'h00112223, 5'd2, 5'd1, 5'd0); tick();
        disp(13, 32'h60000034, 32'h00000013, 5'd0, 5'd0, 5'd5);
        wb(12, 32'h70000000, 32'hDEADBEEF, 32'h55, 1'b0, 32'd0);
        mem(12, 32'h70000004, 32'd0, 32'hDEADBEEF, 4'h0, 4'hF); tick();
        disp(14, 32'h60000038, 32'h00002503, 5'd0, 5'd0, 5'd10);
        wb(14, 32'd0, 32'd0, 32'h77, 1'b0, 32'd0);
        mem(14, 32'h1234, 32'hAAAA, 32'd0, 4'hF, 4'h0); tick();
        com1(12); wb(13, 32'd0, 32'd0, 32'h13, 1'b0, 32'd0); tick();
        chk("st_order", rvfi_order[63:0], 64'd9);
        chk("st_rd_wdata", 64'(rvfi_rd_wdata[31:0]), 64'd0);
        chk("st_wmask", 64'(rvfi_mem_wmask[3:0]), 64'hF);
        chk("st_rmask", 64'(rvfi_mem_rmask[3:0]), 64'd0);
        chk("st_addr", 64'(rvfi_mem_addr[31:0]), 64'h70000004);
        chk("st_wdata", 64'(rvfi_mem_wdata[31:0]), 64'hDEADBEEF);
        wb(14, 32'd0, 32'd0, 32'h99, 1'b0, 32'd0); tick();
        com2(13, 14); tick();
        chk("dw_order1", rvfi_order[127:64], 64'd11);
        chk("dw_rd_wdata1", 64'(rvfi_rd_wdata[63:32]), 64'h99);
        chk("dw_rmask1", 64'(rvfi_mem_rmask[7:4]), 64'd0);

        disp(15, 32'h60000040, 32'h00000013, 5'd1, 5'd0, 5'd3); tick();
        wb(15, 32'h5, 32'h6, 32'h7, 1'b0, 32'd0); tick();
        commit_valid = 2'b10; commit_rob_idx = {4'd15, 4'd0}; tick();
        chk("nc_valid", 64'(rvfi_valid), 64'd0);
        com1(15); tick();
        chk("nc_order", rvfi_order[63:0], 64'd12);

        disp(3, 32'h60000050, 32'h00000013, 5'd1, 5'd2, 5'd6); tick();
        wb(3, 32'h1, 32'h2, 32'h33, 1'b0, 32'd0); disp(0, 32'h60000054, 32'h00000013, 5'd1, 5'd2, 5'd7); tick();
        wb(0, 32'h8, 32'h9, 32'h44, 1'b0, 32'd0); disp(1, 32'h60000058, 32'h00000013, 5'd1, 5'd2, 5'd8); tick();
        disp(2, 32'h6000005c, 32'h00000013, 5'd1, 5'd2, 5'd9); tick();
        flush = 1; com1(3); disp(4, 32'h60000060, 32'h00000013, 5'd1, 5'd2, 5'd9); tick();
        chk("fl_valid", 64'(rvfi_valid), 64'd1);
        chk("fl_order", rvfi_order[63:0], 64'd13);
        run(5, 32'h60000080, 32'h00000013, 5'd4, 32'h5a);
        chk("fl_next_order", rvfi_order[63:0], 64'd14);

        disp(6, 32'h60000090, 32'h00000013, 5'd1, 5'd2, 5'd3); tick();
        wb(6, 32'h1, 32'h2, 32'h3, 1'b0, 32'd0); tick();
        com1(6); rst = 0; tick();
        chk("mr_dropped", 64'(rvfi_valid), 64'd0);
        rst = 1;
        run(7, 32'h600000a0, 32'h00000013, 5'd3, 32'h21);
        chk("mr_valid", 64'(rvfi_valid), 64'd1);
        chk("mr_order", rvfi_order[63:0], 64'd0);

`ifdef RVFI_TRACKER_CHECK_EN
        chk("err_clear", 64'(err), 64'd0);
        disp(0, 32'h600000b0, 32'h00000013, 5'd1, 5'd2, 5'd3); tick();
        com1(0); tick();
        chk("err_set", 64'(err), 64'd1);
        tick(); tick();
        chk("err_sticky", 64'(err), 64'd1);
        rst = 0; tick();
        chk("err_reset", 64'(err), 64'd0);
        rst = 1;
`endif
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
